// File: rtl/shift_fifo_pkg.sv
// Shared definitions for the shift-register FIFO.
// Holds the default WIDTH/DEPTH used by both the register chain and
// its reader, and the helper that sizes the entry counter.
package shift_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 16;

  // Counter must represent 0..DEPTH inclusive.
  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_fifo_reader_tap_select.sv
// tap_select: combinational DEPTH:1 mux that picks the oldest valid tap.
// Ports:
//   taps_i  - parallel chain contents, tap 0 newest
//   count_i - number of valid chain entries (0..DEPTH)
//   data_o  - taps_i[count_i-1], or 0 when count_i is 0
module tap_select
  import shift_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic [DEPTH-1:0][WIDTH-1:0]      taps_i,
  input  logic [count_width(DEPTH)-1:0]    count_i,
  output logic [WIDTH-1:0]                 data_o
);

  localparam int unsigned CW = count_width(DEPTH);

  // Matching against i+1 avoids a subtract and yields 0 for count 0.
  always_comb begin
    data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (count_i == CW'(i + 1)) begin
        data_o = taps_i[i];
      end
    end
  end

endmodule

// File: rtl/shift_fifo_reader.sv
// shift_fifo_reader: read side of a shift-register FIFO.
// Tracks how many chain entries are valid, selects the oldest one and
// moves it into a registered valid/ready output stage.
// Ports:
//   clk_i      - clock, rising edge
//   rst_i      - synchronous active-low reset
//   push_i     - write strobe that shifts the chain at this edge
//   taps_i     - chain contents, tap 0 newest
//   ready_i    - consumer accepts data_o this cycle
//   valid_o    - data_o holds a valid entry
//   data_o     - oldest entry, registered
//   count_o    - valid entries still in the chain (excludes output stage)
//   full_o     - count_o == DEPTH
//   empty_o    - nothing in chain and nothing in the output stage
//   overflow_o - sticky: push while full with no load
module shift_fifo_reader
  import shift_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [DEPTH-1:0][WIDTH-1:0]    taps_i,
  input  logic                           ready_i,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               data_o,
  output logic [count_width(DEPTH)-1:0]  count_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic                           overflow_o
);

  localparam int unsigned CW = count_width(DEPTH);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEPTH);

  logic [CW-1:0]    count_q, count_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] oldest;
  logic             load;
  logic             is_full;

  tap_select #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_tap_select (
    .taps_i  (taps_i),
    .count_i (count_q),
    .data_o  (oldest)
  );

  assign is_full = (count_q == COUNT_MAX);
  assign load    = (count_q != '0) && (!valid_q || ready_i);

  always_comb begin
    count_d    = count_q;
    overflow_d = overflow_q;
    valid_d    = valid_q;
    data_d     = data_q;

    // Taps are pre-shift, so count-1 still addresses the oldest entry even
    // when a push shifts the chain at this same edge.
    if (load) begin
      data_d  = oldest;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end

    if (push_i && !load) begin
      if (is_full) begin
        // Chain drops its oldest tap; count stays saturated.
        overflow_d = 1'b1;
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (load && !push_i) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_q    <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign count_o    = count_q;
  assign full_o     = is_full;
  assign empty_o    = (count_q == '0) && !valid_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_shift_fifo_reader.sv
module tb_shift_fifo_reader;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b0;
  logic                        push_i = 1'b0;
  logic [WIDTH-1:0]            wdata = '0;
  logic [DEPTH-1:0][WIDTH-1:0] chain = '0;
  logic                        ready_i = 1'b0;
  logic                        valid_o;
  logic [WIDTH-1:0]            data_o;
  logic [CW-1:0]               count_o;
  logic                        full_o;
  logic                        empty_o;
  logic                        overflow_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sb[$];

  always #5 clk_i = ~clk_i;

  // Register chain model: shifts on every push, never reset.
  always @(posedge clk_i) begin
    if (push_i) chain <= {chain[DEPTH-2:0], wdata};
  end

  shift_fifo_reader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_i),
    .taps_i     (chain),
    .ready_i    (ready_i),
    .valid_o    (valid_o),
    .data_o     (data_o),
    .count_o    (count_o),
    .full_o     (full_o),
    .empty_o    (empty_o),
    .overflow_o (overflow_o)
  );

  // Monitor: every accepted output word is checked against the scoreboard.
  always @(negedge clk_i) begin
    if (rst_i && valid_o && ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data 0x%0h, expected no output", data_o);
      end else begin
        logic [WIDTH-1:0] exp;
        exp = sb.pop_front();
        if (data_o !== exp) begin
          n_err++;
          $display("FAIL sb_data: got 0x%0h, expected 0x%0h", data_o, exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Push one word; exp_out says whether it should eventually be read out.
  task automatic push(input logic [WIDTH-1:0] v, input bit exp_out);
    push_i = 1'b1;
    wdata  = v;
    if (exp_out) sb.push_back(v);
    tick();
    push_i = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned cyc;
    ready_i = 1'b1;
    cyc = 0;
    while ((sb.size() != 0 || valid_o) && cyc < 100) begin
      tick();
      cyc++;
    end
    check({name, "_drain_timeout"}, (sb.size() != 0 || valid_o) ? 1 : 0, 0);
    ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    tick();
    tick();
    sb.delete();
    rst_i = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();
    tick();
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_data", data_o, 0);
    check("rst_ovf", overflow_o, 0);

    // Three pushes, consumer stalled.
    push(32'hA1, 1);
    check("lat_count1", count_o, 1);
    check("lat_valid0", valid_o, 0);
    push(32'hB2, 1);
    check("lat_valid1", valid_o, 1);
    check("lat_data", data_o, 32'hA1);
    push(32'hC3, 1);
    check("stall_count2", count_o, 2);
    check("stall_hold", data_o, 32'hA1);
    drain("stall");
    check("stall_empty", empty_o, 1);

    // Streaming with ready held high.
    ready_i = 1'b1;
    push(32'hA1, 1);
    push(32'hB2, 1);
    push(32'hC3, 1);
    drain("stream");
    tick();
    check("stream_empty", empty_o, 1);

    // Fill to full, then push and pop together.
    for (int i = 0; i <= 16; i++) push(WIDTH'(i), 1);
    check("fill_count", count_o, 16);
    check("fill_full", full_o, 1);
    check("fill_valid", valid_o, 1);
    check("fill_data", data_o, 0);
    check("fill_ovf", overflow_o, 0);
    ready_i = 1'b1;
    push(32'h20, 1);
    ready_i = 1'b0;
    check("fullpp_count", count_o, 16);
    check("fullpp_ovf", overflow_o, 0);
    check("fullpp_data", data_o, 32'h01);
    drain("fullpp");

    // Overflow: 18 pushes while stalled, 0x01 is dropped by the chain.
    do_reset();
    for (int i = 0; i <= 16; i++) push(WIDTH'(i), i != 1);
    check("ovf_pre", overflow_o, 0);
    push(32'h11, 1);
    check("ovf_set", overflow_o, 1);
    check("ovf_count", count_o, 16);
    drain("ovf");
    check("ovf_sticky", overflow_o, 1);

    // Reset mid-stream with count 5 and output valid.
    do_reset();
    for (int i = 0; i < 6; i++) push(WIDTH'(32'h30 + i), 1);
    check("mid_count5", count_o, 5);
    check("mid_valid", valid_o, 1);
    do_reset();
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_count", count_o, 0);
    check("mid_rst_ovf", overflow_o, 0);
    push(32'h5A, 1);
    drain("mid");
    check("mid_empty", empty_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
